// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and default bit period.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } uart_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 501;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high lines do not glitch out of reset.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, validates the start bit at mid-bit, samples data
// bits at their centres and checks the stop bit, strobing rx_done or framing_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       framing_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  logic s2;
  logic prev_q;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (s2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      prev_q  <= s2;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      StIdle: begin
        // Edge-triggered so a held-low (break) line never restarts a frame.
        if (!s2 && prev_q) begin
          state_d = StStart;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StStart: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d  = '0;
          bitn_d = '0;
          state_d = s2 ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {s2, shift_q[DATA_BITS-1:1]};
          if (bitn_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bitn_d = bitn_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        // Leaving at mid-stop-bit lets the next start edge be caught with no dead time.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (s2) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out    = data_q;
  assign rx_done     = done_q;
  assign framing_err = ferr_q;
  assign rx_busy     = (state_q != StIdle);

endmodule
